// File: rtl/spram_color_cycler.sv
// Purpose: writes four colors into an on-chip single-port RAM, then cycles them onto the LEDs; also the two UART tx-data muxes.
// Latency: led follows an address advance by 2 edges; one color lasts PERIOD+3 RUN edges; the tx muxes are combinational.
// Backpressure: none; free-running sequencer with no handshake.
module spram_color_cycler #(
    parameter logic [31:0] PERIOD = 32'h0100_0000,
    parameter int          DEPTH  = 16384
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] led,
    input  logic [7:0] tx0_a,
    input  logic [7:0] tx0_b,
    input  logic       tx0_sel,
    output logic [7:0] tx0_z,
    input  logic [7:0] tx1_a,
    input  logic [7:0] tx1_b,
    input  logic       tx1_sel,
    output logic [7:0] tx1_z
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] ADV_CNT   = PERIOD;
    localparam logic [31:0] LATCH_CNT = PERIOD + 32'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT0 = 3'd1,
        INIT1 = 3'd2,
        INIT2 = 3'd3,
        INIT3 = 3'd4,
        RUN   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   counter, counter_nxt;
    logic [2:0]    led_nxt;
    logic [AW-1:0] ram_addr, ram_addr_nxt;
    logic [15:0]   ram_din, ram_din_nxt;
    logic          ram_wren, ram_wren_nxt;
    logic [15:0]   ram_dout;
    logic [15:0]   mem [DEPTH];

    // Only the low three color bits drive LEDs; the rest of each word is carried but not shown.
    logic unused_dout_bits;
    assign unused_dout_bits = ^ram_dout[15:3];

    // Transmit-data selectors, independent per channel.
    always_comb begin
        tx0_z = tx0_sel ? tx0_b : tx0_a;
        tx1_z = tx1_sel ? tx1_b : tx1_a;
    end

    // RAM array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_din;
        end
    end

    // RAM synchronous read; returns old data on a write cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_dout <= 16'h0000;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    // Next-state and datapath decode: init writes, then counter-paced address advance and LED latch.
    always_comb begin
        state_nxt    = state;
        counter_nxt  = counter;
        led_nxt      = led;
        ram_addr_nxt = ram_addr;
        ram_din_nxt  = ram_din;
        ram_wren_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            INIT0: begin
                ram_addr_nxt = AW'(0);
                ram_din_nxt  = 16'h0001;
                ram_wren_nxt = 1'b1;
                state_nxt    = INIT1;
            end
            INIT1: begin
                ram_addr_nxt = AW'(1);
                ram_din_nxt  = 16'h0002;
                ram_wren_nxt = 1'b1;
                state_nxt    = INIT2;
            end
            INIT2: begin
                ram_addr_nxt = AW'(2);
                ram_din_nxt  = 16'h0004;
                ram_wren_nxt = 1'b1;
                state_nxt    = INIT3;
            end
            INIT3: begin
                ram_addr_nxt = AW'(3);
                ram_din_nxt  = 16'h0007;
                ram_wren_nxt = 1'b1;
                state_nxt    = RUN;
            end
            RUN: begin
                counter_nxt = counter + 32'd1;
                // Only the 2-bit color index moves; the upper address bits never carry.
                if (counter == ADV_CNT) begin
                    ram_addr_nxt = {ram_addr[AW-1:2], ram_addr[1:0] + 2'd1};
                end
                // Two edges after the advance the RAM output reflects the new address.
                if (counter == LATCH_CNT) begin
                    led_nxt     = ram_dout[2:0];
                    counter_nxt = 32'd0;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset back to INIT0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT0;
            counter  <= 32'd0;
            led      <= 3'd0;
            ram_addr <= '0;
            ram_din  <= 16'h0000;
            ram_wren <= 1'b0;
        end else begin
            state    <= state_nxt;
            counter  <= counter_nxt;
            led      <= led_nxt;
            ram_addr <= ram_addr_nxt;
            ram_din  <= ram_din_nxt;
            ram_wren <= ram_wren_nxt;
        end
    end

endmodule

// File: tb/tb_spram_color_cycler.sv
// Purpose: self-checking bench for spram_color_cycler with a small period and randomized mux traffic.
// Latency: expectations derived from the edge count since reset release.
// Backpressure: not applicable.
module tb_spram_color_cycler;

    localparam logic [31:0] P   = 32'd4;
    localparam int          CYC = 7;   // PERIOD + 3 RUN edges per color

    logic       clk;
    logic       rst;
    logic [2:0] led;
    logic [7:0] tx0_a, tx0_b, tx0_z;
    logic       tx0_sel;
    logic [7:0] tx1_a, tx1_b, tx1_z;
    logic       tx1_sel;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;   // rising edges since reset release

    spram_color_cycler #(.PERIOD(P), .DEPTH(16384)) dut (
        .clk     (clk),
        .rst     (rst),
        .led     (led),
        .tx0_a   (tx0_a),
        .tx0_b   (tx0_b),
        .tx0_sel (tx0_sel),
        .tx0_z   (tx0_z),
        .tx1_a   (tx1_a),
        .tx1_b   (tx1_b),
        .tx1_sel (tx1_sel),
        .tx1_z   (tx1_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Display color order: red, green, blue, white.
    function automatic logic [31:0] color(input int i);
        case (i % 4)
            0:       return 32'd1;
            1:       return 32'd2;
            2:       return 32'd4;
            default: return 32'd7;
        endcase
    endfunction

    // Reference model: everything as a function of edges since reset release.
    // Edges 1..4 are INIT0..INIT3; RUN edge r = k-4.
    function automatic logic [31:0] exp_wren(input int e);
        return (e >= 1 && e <= 4) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_addr(input int e);
        int r;
        int adv;
        if (e == 0) return 32'd0;
        if (e <= 4) return 32'(e - 1);
        r   = e - 4;
        adv = (r < P + 1) ? 0 : (r - (P + 1)) / CYC + 1;
        return 32'((3 + adv) % 4);
    endfunction

    function automatic logic [31:0] exp_din(input int e);
        if (e == 0) return 32'd0;
        if (e <= 4) return color(e - 1);
        return 32'd7;
    endfunction

    function automatic logic [31:0] exp_cnt(input int e);
        if (e <= 4) return 32'd0;
        return 32'((e - 4) % CYC);
    endfunction

    function automatic logic [31:0] exp_led(input int e);
        int r;
        if (e <= 4) return 32'd0;
        r = e - 4;
        if (r < CYC) return 32'd0;
        return color(r / CYC - 1);
    endfunction

    task automatic mux_random_check();
        tx0_a   = 8'($urandom);
        tx0_b   = 8'($urandom);
        tx0_sel = 1'($urandom);
        tx1_a   = 8'($urandom);
        tx1_b   = 8'($urandom);
        tx1_sel = 1'($urandom);
        #1;
        check_eq("tx0_z", 32'(tx0_z), 32'(tx0_sel ? tx0_b : tx0_a));
        check_eq("tx1_z", 32'(tx1_z), 32'(tx1_sel ? tx1_b : tx1_a));
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_eq("led",      32'(led),          exp_led(k));
            check_eq("ram_wren", 32'(dut.ram_wren), exp_wren(k));
            check_eq("ram_addr", 32'(dut.ram_addr), exp_addr(k));
            check_eq("ram_din",  32'(dut.ram_din),  exp_din(k));
            check_eq("counter",  dut.counter,       exp_cnt(k));
            mux_random_check();
        end
    endtask

    initial begin
        rst     = 1'b1;
        tx0_a   = 8'h00; tx0_b = 8'h00; tx0_sel = 1'b0;
        tx1_a   = 8'h00; tx1_b = 8'h00; tx1_sel = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_eq("rst_led",   32'(led),          32'd0);
        check_eq("rst_wren",  32'(dut.ram_wren), 32'd0);
        check_eq("rst_addr",  32'(dut.ram_addr), 32'd0);
        check_eq("rst_din",   32'(dut.ram_din),  32'd0);
        check_eq("rst_cnt",   dut.counter,       32'd0);
        check_eq("rst_dout",  32'(dut.ram_dout), 32'd0);
        check_eq("rst_state", 32'(dut.state),    32'd1);

        // Directed mux: channel 0 toggles, channel 1 held at other values.
        tx0_a = 8'h55; tx0_b = 8'hAA;
        tx1_a = 8'h3C; tx1_b = 8'hC3; tx1_sel = 1'b1;
        tx0_sel = 1'b0; #1;
        check_eq("mux0_sel0", 32'(tx0_z), 32'h55);
        check_eq("mux1_hold", 32'(tx1_z), 32'hC3);
        tx0_sel = 1'b1; #1;
        check_eq("mux0_sel1", 32'(tx0_z), 32'hAA);
        check_eq("mux1_hold", 32'(tx1_z), 32'hC3);
        tx1_sel = 1'b0; #1;
        check_eq("mux1_sel0", 32'(tx1_z), 32'h3C);
        check_eq("mux0_hold", 32'(tx0_z), 32'hAA);

        // Release and run well past eight color periods.
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        run_edges(75);

        // Asynchronous reset between edges, mid-RUN with a color showing.
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_led",   32'(led),          32'd0);
        check_eq("arst_state", 32'(dut.state),    32'd1);
        check_eq("arst_cnt",   dut.counter,       32'd0);
        check_eq("arst_addr",  32'(dut.ram_addr), 32'd0);
        check_eq("arst_wren",  32'(dut.ram_wren), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        run_edges(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
